// File: rtl/writeback_queue_pkg.sv
// -----------------------------------------------------------------------------
// writeback_queue_pkg
// Shared register-file constants for the writeback queue and its forwarding
// selector: register address width, data width and the default queue depth.
// -----------------------------------------------------------------------------
package writeback_queue_pkg;

    localparam int REG_ADDR_W        = 5;
    localparam int REG_DATA_W        = 32;
    localparam int WBQ_DEPTH_DEFAULT = 4;

endpackage : writeback_queue_pkg

// File: rtl/writeback_queue_match.sv
// -----------------------------------------------------------------------------
// wbq_match
// Combinational newest-match forwarding selector for one register read port.
// Entries arrive ordered by age (index 0 = oldest, i.e. the queue head), so the
// highest-indexed valid entry whose address matches wins. Register 0 always
// reads as zero.
//
// Ports
//   rd_addr_i    operand register address
//   rf_data_i    register-file read data for rd_addr_i
//   ent_valid_i  per-entry valid, age ordered
//   ent_addr_i   per-entry destination address, age ordered
//   ent_data_i   per-entry destination value, age ordered
//   fwd_data_o   operand value including pending writes
// -----------------------------------------------------------------------------
module wbq_match
    import writeback_queue_pkg::*;
#(
    parameter int DEPTH = WBQ_DEPTH_DEFAULT
) (
    input  logic [REG_ADDR_W-1:0] rd_addr_i,
    input  logic [REG_DATA_W-1:0] rf_data_i,
    input  logic [DEPTH-1:0]      ent_valid_i,
    input  logic [REG_ADDR_W-1:0] ent_addr_i [DEPTH],
    input  logic [REG_DATA_W-1:0] ent_data_i [DEPTH],
    output logic [REG_DATA_W-1:0] fwd_data_o
);

    logic [REG_DATA_W-1:0] sel_data_s;

    // Scan oldest to newest so that the newest matching entry overrides older ones.
    always_comb begin
        sel_data_s = rf_data_i;
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_valid_i[i] && (ent_addr_i[i] == rd_addr_i)) begin
                sel_data_s = ent_data_i[i];
            end else begin
                sel_data_s = sel_data_s;
            end
        end
    end

    // Register 0 is hard-wired to zero regardless of register-file contents.
    always_comb begin
        if (rd_addr_i == {REG_ADDR_W{1'b0}}) begin
            fwd_data_o = {REG_DATA_W{1'b0}};
        end else begin
            fwd_data_o = sel_data_s;
        end
    end

endmodule : wbq_match

// File: rtl/writeback_queue.sv
// -----------------------------------------------------------------------------
// writeback_queue
// Circular FIFO of pending register-file writes. The head entry drains to the
// register file whenever the queue is non-empty and not stalled; every pending
// entry is visible to the operand forwarding paths so reads see the newest
// queued value. Writes to register 0 are accepted but dropped.
//
// Ports
//   clock, resetn               clock, asynchronous active-low reset
//   in_valid/in_ready           producer handshake
//   in_addr/in_data             destination register and value
//   stall                       inhibits draining this cycle
//   RegWrite/WriteRegister/
//   WriteData                   register-file write port
//   ReadRegister1/2, rf_data1/2 operand addresses and register-file read data
//   fwd_data1/2                 forwarded operand values
//   count                       occupied entries
// -----------------------------------------------------------------------------
module writeback_queue
    import writeback_queue_pkg::*;
#(
    parameter int DEPTH = WBQ_DEPTH_DEFAULT
) (
    input  logic                      clock,
    input  logic                      resetn,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [REG_ADDR_W-1:0]     in_addr,
    input  logic [REG_DATA_W-1:0]     in_data,
    input  logic                      stall,
    output logic                      RegWrite,
    output logic [REG_ADDR_W-1:0]     WriteRegister,
    output logic [REG_DATA_W-1:0]     WriteData,
    input  logic [REG_ADDR_W-1:0]     ReadRegister1,
    input  logic [REG_ADDR_W-1:0]     ReadRegister2,
    input  logic [REG_DATA_W-1:0]     rf_data1,
    input  logic [REG_DATA_W-1:0]     rf_data2,
    output logic [REG_DATA_W-1:0]     fwd_data1,
    output logic [REG_DATA_W-1:0]     fwd_data2,
    output logic [$clog2(DEPTH):0]    count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0]         head_q, head_d;
    logic [PW-1:0]         tail_q, tail_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  ready_q;
    logic [REG_ADDR_W-1:0] addr_q [DEPTH];
    logic [REG_DATA_W-1:0] data_q [DEPTH];

    logic                  push_s;
    logic                  enq_s;
    logic                  pop_s;
    logic [PW-1:0]         slot_s;
    logic [DEPTH-1:0]      ord_valid_s;
    logic [REG_ADDR_W-1:0] ord_addr_s [DEPTH];
    logic [REG_DATA_W-1:0] ord_data_s [DEPTH];

    // Accepted register-0 writes complete immediately and never occupy an entry.
    assign push_s   = in_valid & ready_q;
    assign enq_s    = push_s & (in_addr != {REG_ADDR_W{1'b0}});
    assign pop_s    = (count_q != {CW{1'b0}}) & ~stall;

    assign in_ready = ready_q;
    assign RegWrite = pop_s;
    assign count    = count_q;

    // Head entry drives the register-file write port; zero when empty.
    always_comb begin
        if (count_q != {CW{1'b0}}) begin
            WriteRegister = addr_q[head_q];
            WriteData     = data_q[head_q];
        end else begin
            WriteRegister = {REG_ADDR_W{1'b0}};
            WriteData     = {REG_DATA_W{1'b0}};
        end
    end

    // Pointer and occupancy next state; pointers wrap naturally at DEPTH (power of two).
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (pop_s) begin
            head_d = head_q + PW'(1);
        end else begin
            head_d = head_q;
        end
        if (enq_s) begin
            tail_d = tail_q + PW'(1);
        end else begin
            tail_d = tail_q;
        end
        case ({enq_s, pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // State registers; in_ready is registered so it stays low until the first edge after reset.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            head_q  <= {PW{1'b0}};
            tail_q  <= {PW{1'b0}};
            count_q <= {CW{1'b0}};
            ready_q <= 1'b0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            ready_q <= (count_d < CW'(DEPTH));
        end
    end

    // Entry storage in flip-flops so every slot is visible to forwarding.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= {REG_ADDR_W{1'b0}};
                data_q[i] <= {REG_DATA_W{1'b0}};
            end
        end else if (enq_s) begin
            addr_q[tail_q] <= in_addr;
            data_q[tail_q] <= in_data;
        end
    end

    // Rotate storage into age order (index 0 = head) for the forwarding selectors.
    always_comb begin
        slot_s = {PW{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            slot_s         = head_q + PW'(i);
            ord_addr_s[i]  = addr_q[slot_s];
            ord_data_s[i]  = data_q[slot_s];
            ord_valid_s[i] = (CW'(i) < count_q);
        end
    end

    wbq_match #(.DEPTH(DEPTH)) u_match1 (
        .rd_addr_i   (ReadRegister1),
        .rf_data_i   (rf_data1),
        .ent_valid_i (ord_valid_s),
        .ent_addr_i  (ord_addr_s),
        .ent_data_i  (ord_data_s),
        .fwd_data_o  (fwd_data1)
    );

    wbq_match #(.DEPTH(DEPTH)) u_match2 (
        .rd_addr_i   (ReadRegister2),
        .rf_data_i   (rf_data2),
        .ent_valid_i (ord_valid_s),
        .ent_addr_i  (ord_addr_s),
        .ent_data_i  (ord_data_s),
        .fwd_data_o  (fwd_data2)
    );

endmodule : writeback_queue

// File: tb/tb_writeback_queue.sv
// -----------------------------------------------------------------------------
// tb_writeback_queue
// Directed bench for writeback_queue (DEPTH = 4). Inputs change 1 ns after a
// rising edge; outputs are checked 1 ns later, well clear of the next edge.
// -----------------------------------------------------------------------------
module tb_writeback_queue;

    logic        clock;
    logic        resetn;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_addr;
    logic [31:0] in_data;
    logic        stall;
    logic        RegWrite;
    logic [4:0]  WriteRegister;
    logic [31:0] WriteData;
    logic [4:0]  ReadRegister1;
    logic [4:0]  ReadRegister2;
    logic [31:0] rf_data1;
    logic [31:0] rf_data2;
    logic [31:0] fwd_data1;
    logic [31:0] fwd_data2;
    logic [2:0]  count;

    int total;
    int bad;

    writeback_queue #(.DEPTH(4)) dut (
        .clock         (clock),
        .resetn        (resetn),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_addr       (in_addr),
        .in_data       (in_data),
        .stall         (stall),
        .RegWrite      (RegWrite),
        .WriteRegister (WriteRegister),
        .WriteData     (WriteData),
        .ReadRegister1 (ReadRegister1),
        .ReadRegister2 (ReadRegister2),
        .rf_data1      (rf_data1),
        .rf_data2      (rf_data2),
        .fwd_data1     (fwd_data1),
        .fwd_data2     (fwd_data2),
        .count         (count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] a, input logic [31:0] d);
        in_valid = v;
        in_addr  = a;
        in_data  = d;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        resetn = 1'b0; stall = 1'b0;
        drive(1'b0, 5'd0, 32'd0);
        ReadRegister1 = 5'd0; ReadRegister2 = 5'd0;
        rf_data1 = 32'd0; rf_data2 = 32'd0;

        // Reset state
        settle();
        chk("rst_count",   32'(count), 32'd0);
        chk("rst_ready",   32'(in_ready), 32'd0);
        chk("rst_regwr",   32'(RegWrite), 32'd0);
        chk("rst_wreg",    32'(WriteRegister), 32'd0);
        chk("rst_wdata",   WriteData, 32'd0);
        tick(); tick();
        resetn = 1'b1;
        tick();
        chk("post_rst_ready", 32'(in_ready), 32'd1);

        // Single push drains the next cycle
        drive(1'b1, 5'd5, 32'hDEADBEEF);
        settle();
        chk("s1_regwr_before", 32'(RegWrite), 32'd0);
        tick();
        drive(1'b0, 5'd0, 32'd0);
        settle();
        chk("s1_count",  32'(count), 32'd1);
        chk("s1_regwr",  32'(RegWrite), 32'd1);
        chk("s1_wreg",   32'(WriteRegister), 32'd5);
        chk("s1_wdata",  WriteData, 32'hDEADBEEF);
        tick();
        chk("s1_count_after", 32'(count), 32'd0);
        chk("s1_regwr_after", 32'(RegWrite), 32'd0);

        // Fill under stall, reject 5th push, drain in order
        stall = 1'b1;
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 5'(k + 1), 32'h100 + 32'(k));
            settle();
            chk("s2_ready_fill", 32'(in_ready), 32'd1);
            tick();
        end
        drive(1'b1, 5'd9, 32'h999);
        settle();
        chk("s2_count_full", 32'(count), 32'd4);
        chk("s2_ready_full", 32'(in_ready), 32'd0);
        chk("s2_regwr_stall", 32'(RegWrite), 32'd0);
        ReadRegister1 = 5'd1; rf_data1 = 32'h77;
        settle();
        chk("s2_fwd_head", fwd_data1, 32'h100);
        tick();
        chk("s2_count_reject", 32'(count), 32'd4);
        drive(1'b0, 5'd0, 32'd0);
        stall = 1'b0;
        for (int k = 0; k < 4; k++) begin
            settle();
            chk("s2_drain_regwr", 32'(RegWrite), 32'd1);
            chk("s2_drain_wreg",  32'(WriteRegister), 32'(k + 1));
            chk("s2_drain_wdata", WriteData, 32'h100 + 32'(k));
            tick();
        end
        chk("s2_count_empty", 32'(count), 32'd0);
        chk("s2_regwr_empty", 32'(RegWrite), 32'd0);

        // Newest duplicate is forwarded
        stall = 1'b1;
        drive(1'b1, 5'd7, 32'h11);
        tick();
        drive(1'b1, 5'd7, 32'h22);
        tick();
        drive(1'b0, 5'd0, 32'd0);
        ReadRegister1 = 5'd7; rf_data1 = 32'h99;
        ReadRegister2 = 5'd7; rf_data2 = 32'h55;
        settle();
        chk("s3_fwd1_newest", fwd_data1, 32'h22);
        chk("s3_fwd2_newest", fwd_data2, 32'h22);
        stall = 1'b0;
        settle();
        chk("s3_first_write", WriteData, 32'h11);
        tick();
        chk("s3_fwd1_one_left", fwd_data1, 32'h22);
        chk("s3_second_write", WriteData, 32'h22);
        tick();
        chk("s3_fwd1_rf", fwd_data1, 32'h99);
        chk("s3_fwd2_rf", fwd_data2, 32'h55);

        // Register-0 write is accepted and dropped; reads of r0 are zero
        drive(1'b1, 5'd0, 32'hFFFFFFFF);
        settle();
        chk("s4_ready", 32'(in_ready), 32'd1);
        tick();
        drive(1'b0, 5'd0, 32'd0);
        ReadRegister2 = 5'd0; rf_data2 = 32'h5;
        settle();
        chk("s4_count", 32'(count), 32'd0);
        chk("s4_regwr", 32'(RegWrite), 32'd0);
        chk("s4_fwd2_zero", fwd_data2, 32'd0);

        // Wrap: head/tail sit at 3; fill two, then push+pop together
        stall = 1'b1;
        drive(1'b1, 5'd10, 32'hA0);
        tick();
        drive(1'b1, 5'd11, 32'hA1);
        tick();
        chk("s5_count2", 32'(count), 32'd2);
        stall = 1'b0;
        drive(1'b1, 5'd12, 32'hA2);
        settle();
        chk("s5_pp_regwr", 32'(RegWrite), 32'd1);
        chk("s5_pp_wdata", WriteData, 32'hA0);
        tick();
        drive(1'b0, 5'd0, 32'd0);
        settle();
        chk("s5_count_same", 32'(count), 32'd2);
        chk("s5_wdata_a1", WriteData, 32'hA1);
        chk("s5_wreg_a1", 32'(WriteRegister), 32'd11);
        tick();
        chk("s5_wdata_a2", WriteData, 32'hA2);
        chk("s5_wreg_a2", 32'(WriteRegister), 32'd12);
        tick();
        chk("s5_count_empty", 32'(count), 32'd0);

        // Asynchronous reset mid-operation with 3 pending entries
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 5'(20 + k), 32'hC0 + 32'(k));
            tick();
        end
        drive(1'b0, 5'd0, 32'd0);
        chk("s6_count3", 32'(count), 32'd3);
        stall = 1'b0;
        settle();
        chk("s6_regwr_pre", 32'(RegWrite), 32'd1);
        resetn = 1'b0;
        settle();
        chk("s6_async_count", 32'(count), 32'd0);
        chk("s6_async_regwr", 32'(RegWrite), 32'd0);
        chk("s6_async_ready", 32'(in_ready), 32'd0);
        chk("s6_async_wdata", WriteData, 32'd0);
        tick();
        chk("s6_hold_regwr", 32'(RegWrite), 32'd0);
        resetn = 1'b1;
        tick();
        chk("s6_ready_after", 32'(in_ready), 32'd1);
        drive(1'b1, 5'd3, 32'hCAFE);
        tick();
        drive(1'b0, 5'd0, 32'd0);
        settle();
        chk("s6_regwr", 32'(RegWrite), 32'd1);
        chk("s6_wreg", 32'(WriteRegister), 32'd3);
        chk("s6_wdata", WriteData, 32'hCAFE);
        tick();
        chk("s6_count_end", 32'(count), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_writeback_queue

// File: doc/writeback_queue.md
WRITEBACK_QUEUE -- requirements
Module: writeback_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning the number of queue entries (power of two, 2..16).
REQ-002 SHALL have port clock  input  1  single clock; all state updates on the rising edge.
REQ-003 SHALL have port resetn  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port in_valid  input  1  producer write request valid.
REQ-005 SHALL have port in_ready  output  1  queue can accept a request this cycle.
REQ-006 SHALL have port in_addr  input  5  destination register.
REQ-007 SHALL have port in_data  input  32  destination value.
REQ-008 SHALL have port stall  input  1  inhibits draining to the register file this cycle.
REQ-009 SHALL have port RegWrite  output  1  register-file write enable.
REQ-010 SHALL have port WriteRegister  output  5  register-file write address.
REQ-011 SHALL have port WriteData  output  32  register-file write data.
REQ-012 SHALL have ports ReadRegister1, ReadRegister2  input  5  operand addresses, also driven to the register file.
REQ-013 SHALL have ports rf_data1, rf_data2  input  32  register-file ReadData1/ReadData2.
REQ-014 SHALL have ports fwd_data1, fwd_data2  output  32  operand values including pending writes.
REQ-015 SHALL have port count  output  $clog2(DEPTH)+1  number of occupied entries.

Function
REQ-016 SHALL accept a request at a rising edge iff in_valid and in_ready are both 1.
REQ-017 SHALL drive in_ready = 1 iff count < DEPTH; a pop in the same cycle SHALL NOT make a full queue ready.
REQ-018 SHALL complete an accepted request with in_addr = 0 without enqueuing it (register 0 is constant zero).
REQ-019 SHALL store entries in FIFO order in a circular buffer with head/tail pointers wrapping from DEPTH-1 to 0.
REQ-020 SHALL drive RegWrite = 1 iff count > 0 and stall = 0, combinationally.
REQ-021 SHALL drive WriteRegister/WriteData from the head entry; both SHALL be 0 when count = 0.
REQ-022 SHALL pop the head at every rising edge where RegWrite = 1 (the register file writes at that same edge).
REQ-023 SHALL update count by +1 on push only, -1 on pop only, and leave it unchanged on simultaneous push and pop.
REQ-024 SHALL give a request written at edge N a minimum latency of one cycle: RegWrite for it asserted at earliest in the cycle after edge N.
REQ-025 SHALL drive fwd_dataK combinationally as the data of the newest valid entry (head entry included) whose address equals ReadRegisterK, else rf_dataK.
REQ-026 SHALL drive fwd_dataK = 0 whenever ReadRegisterK = 0, regardless of rf_dataK.
REQ-027 SHALL NOT forward from in_data of a request not yet accepted.
REQ-028 SHALL allow multiple entries with the same address; only the newest is forwarded, and all are written in order.

Reset
REQ-029 SHALL, while resetn = 0, force count = 0, head = tail = 0, in_ready = 0, and RegWrite = 0; WriteRegister and WriteData = 0.
REQ-030 SHALL discard all pending entries on reset assertion mid-operation, with no register-file write issued while resetn = 0.
REQ-031 SHALL assert in_ready = 1 from the first rising edge after resetn deasserts.

Structure
REQ-032 SHALL take DEPTH default, the register address width (5) and the data width (32) from the shared register-file constants package.
REQ-033 SHALL instantiate one sub-module wbq_match, a combinational newest-match forwarding selector, once per read port.
REQ-034 SHALL implement entry storage as flip-flops, not memory macros, so that all entries are visible to forwarding.

Verification
REQ-035 SHALL cover this scenario: push (5, 0xDEADBEEF) with stall = 0 -> next cycle RegWrite = 1, WriteRegister = 5, WriteData = 0xDEADBEEF; count returns to 0.
REQ-036 SHALL cover this scenario: stall = 1, push 4 entries -> count = 4 and in_ready = 0; a 5th push is not accepted; release stall -> 4 writes in push order on 4 consecutive cycles.
REQ-037 SHALL cover this scenario: stall = 1, push (7, 0x11) then (7, 0x22), ReadRegister1 = 7, rf_data1 = 0x99 -> fwd_data1 = 0x22; after draining, fwd_data1 = rf_data1.
REQ-038 SHALL cover this scenario: push (0, 0xFFFFFFFF) -> accepted, count stays 0, no RegWrite; ReadRegister2 = 0 with rf_data2 = 0x5 -> fwd_data2 = 0.
REQ-039 SHALL cover this scenario: queue at count = 2 with pointers wrapped; push and pop in the same cycle -> count stays 2 and FIFO order is preserved across the wrap.
REQ-040 SHALL cover this scenario: assert resetn = 0 asynchronously with 3 entries pending -> RegWrite = 0 and count = 0 immediately; after release, first push drains normally.
